// File: rtl/lns_gauss_interp_lut.sv
// Gaussian-log lookup for the LNS fmadd datapath. It holds two runtime-loadable tables
// (sb = log-add, db = log-subtract), reads T[idx] and T[idx+1] for a fixed-point z, and
// returns the linearly interpolated correction. Two pipeline stages with one stall enable.
module lns_gauss_interp_lut #(
    parameter int unsigned Z_W    = 6,
    parameter int unsigned FRAC_W = 2,
    parameter int unsigned OUT_W  = 11
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_op,
    input  logic [Z_W+FRAC_W-1:0]   in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_ninf,
    input  logic                    cfg_we,
    input  logic                    cfg_sel,
    input  logic [Z_W-1:0]          cfg_addr,
    input  logic signed [OUT_W-1:0] cfg_data
);

    localparam int unsigned DEPTH = 2 ** Z_W;
    localparam int unsigned PW    = OUT_W + FRAC_W + 1;
    localparam logic signed [OUT_W-1:0] NINF_VAL = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [OUT_W-1:0] sb_tab [DEPTH];
    logic signed [OUT_W-1:0] db_tab [DEPTH];

    logic                    en;
    logic [Z_W-1:0]          idx;
    logic [Z_W-1:0]          idx_nxt;
    logic [FRAC_W-1:0]       frac;
    logic                    last;
    logic signed [OUT_W-1:0] rd_lo;
    logic signed [OUT_W-1:0] rd_hi;
    logic [FRAC_W-1:0]       rd_frac;
    logic                    rd_ninf;

    logic                    s1_valid;
    logic signed [OUT_W-1:0] s1_lo;
    logic signed [OUT_W-1:0] s1_hi;
    logic [FRAC_W-1:0]       s1_frac;
    logic                    s1_ninf;

    logic signed [OUT_W:0]   diff;
    logic signed [PW-1:0]    diff_ext;
    logic signed [PW-1:0]    frac_ext;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_sh;
    logic signed [PW-1:0]    sum;
    logic signed [OUT_W-1:0] interp;
    logic                    unused_sum;

    // Whole pipe advances together; a full output that is not taken freezes everything.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Table storage: config writes land on the edge regardless of handshake state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_tab[i] <= '0;
                db_tab[i] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_sel) db_tab[cfg_addr] <= cfg_data;
            else         sb_tab[cfg_addr] <= cfg_data;
        end
    end

    // Table read for the incoming request; the top entry has no upper neighbour.
    always_comb begin
        idx     = in_z[Z_W+FRAC_W-1:FRAC_W];
        frac    = in_z[FRAC_W-1:0];
        last    = &idx;
        idx_nxt = idx + Z_W'(1);
        rd_lo   = in_op ? db_tab[idx] : sb_tab[idx];
        rd_hi   = rd_lo;
        rd_frac = '0;
        if (!last) begin
            rd_hi   = in_op ? db_tab[idx_nxt] : sb_tab[idx_nxt];
            rd_frac = frac;
        end
        rd_ninf = in_op && (in_z == '0);
    end

    // Stage 1: latch both neighbouring entries so later writes cannot disturb them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_hi    <= '0;
            s1_frac  <= '0;
            s1_ninf  <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo   <= rd_lo;
                s1_hi   <= rd_hi;
                s1_frac <= rd_frac;
                s1_ninf <= rd_ninf;
            end
        end
    end

    // Interpolation: lo + floor((hi - lo) * frac / 2**FRAC_W); result stays between entries.
    always_comb begin
        diff       = {s1_hi[OUT_W-1], s1_hi} - {s1_lo[OUT_W-1], s1_lo};
        diff_ext   = {{FRAC_W{diff[OUT_W]}}, diff};
        frac_ext   = {{(OUT_W+1){1'b0}}, s1_frac};
        prod       = diff_ext * frac_ext;
        prod_sh    = prod >>> FRAC_W;
        sum        = {{(FRAC_W+1){s1_lo[OUT_W-1]}}, s1_lo} + prod_sh;
        interp     = sum[OUT_W-1:0];
        unused_sum = ^sum[PW-1:OUT_W];
    end

    // Stage 2: result register, held stable while stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ninf  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_ninf ? NINF_VAL : interp;
                out_ninf <= s1_ninf;
            end
        end
    end

endmodule
